// File: rtl/mem_access.sv
// Memory-access stage of the RV32I pipeline: decodes load/store, runs the
// req/ack data-memory handshake with a bounded wait, aligns store data,
// extracts load data and registers everything into the writeback register.
module mem_access #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_mem,
  input  logic [XLEN-1:0] pc_mem,
  input  logic [XLEN-1:0] alu_mem,
  input  logic [XLEN-1:0] rs2_mem,
  input  logic [XLEN-1:0] instr_mem,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ack,
  output logic            stall_mem,
  output logic [XLEN-1:0] pc_wb,
  output logic [XLEN-1:0] alu_wb,
  output logic [XLEN-1:0] load_wb,
  output logic [XLEN-1:0] instr_wb,
  output logic            valid_wb,
  output logic            exc_wb,
  output logic [3:0]      cause_wb
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // The first request cycle is spent in IDLE, so the wait counter only has to
  // reach TIMEOUT-2 for the whole access to take TIMEOUT cycles.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            valid_wb_q, valid_wb_d, exc_wb_q, exc_wb_d;
  logic [3:0]      cause_wb_q, cause_wb_d;
  logic [XLEN-1:0] pc_wb_q, pc_wb_d, alu_wb_q, alu_wb_d;
  logic [XLEN-1:0] load_wb_q, load_wb_d, instr_wb_q, instr_wb_d;

  logic [2:0]      funct3;
  logic            is_load, is_store, is_mem, misal, mem_go;
  logic            req, timeout_hit, stall;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata, rsh, ld_ext;

  assign funct3   = instr_mem[14:12];
  assign is_load  = (instr_mem[6:0] == 7'b0000011);
  assign is_store = (instr_mem[6:0] == 7'b0100011);
  assign is_mem   = is_load | is_store;

  // Alignment check, lane enables and lane-replicated store data by size
  always_comb begin
    misal = 1'b0;
    be    = 4'b1111;
    wdata = rs2_mem;
    case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << alu_mem[1:0];
        wdata = {4{rs2_mem[7:0]}};
      end
      2'b01: begin
        misal = alu_mem[0];
        be    = alu_mem[1] ? 4'b1100 : 4'b0011;
        wdata = {2{rs2_mem[15:0]}};
      end
      default: misal = |alu_mem[1:0];
    endcase
  end

  // Load extraction: bring the addressed lane down to bit 0 then extend
  always_comb begin
    rsh    = dmem_rdata >> {alu_mem[1:0], 3'b000};
    ld_ext = rsh;
    case (funct3[1:0])
      2'b00:   ld_ext = funct3[2] ? {{(XLEN-8){1'b0}}, rsh[7:0]}
                                  : {{(XLEN-8){rsh[7]}}, rsh[7:0]};
      2'b01:   ld_ext = funct3[2] ? {{(XLEN-16){1'b0}}, rsh[15:0]}
                                  : {{(XLEN-16){rsh[15]}}, rsh[15:0]};
      default: ld_ext = rsh;
    endcase
  end

  // Gating with rst_n drops the request the instant reset asserts
  assign mem_go      = valid_mem & is_mem & ~misal;
  assign req         = rst_n & ((state_q == S_WAIT) | mem_go);
  assign timeout_hit = (state_q == S_WAIT) & (cnt_q == CNT_LAST);
  assign stall       = req & ~dmem_ack & ~timeout_hit;

  assign dmem_req   = req;
  assign dmem_we    = req & is_store;
  assign dmem_addr  = req ? {alu_mem[XLEN-1:2], 2'b00} : '0;
  assign dmem_be    = req ? be : 4'b0000;
  assign dmem_wdata = req ? wdata : '0;
  assign stall_mem  = stall;

  // Handshake FSM next state: IDLE issues, WAIT counts until ack or timeout
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (req && !dmem_ack) begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: if (dmem_ack || timeout_hit) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Writeback next value: bubble while stalled, otherwise retire this entry
  always_comb begin
    valid_wb_d = 1'b0;
    pc_wb_d    = pc_wb_q;
    alu_wb_d   = alu_wb_q;
    instr_wb_d = instr_wb_q;
    load_wb_d  = load_wb_q;
    exc_wb_d   = exc_wb_q;
    cause_wb_d = cause_wb_q;
    if (!stall) begin
      valid_wb_d = valid_mem;
      pc_wb_d    = pc_mem;
      alu_wb_d   = alu_mem;
      instr_wb_d = instr_mem;
      load_wb_d  = (valid_mem && is_load && req && dmem_ack) ? ld_ext : '0;
      exc_wb_d   = 1'b0;
      cause_wb_d = 4'd0;
      if (valid_mem && is_mem && misal) begin
        exc_wb_d   = 1'b1;
        cause_wb_d = is_load ? 4'd4 : 4'd6;
      end else if (req && !dmem_ack && timeout_hit) begin
        exc_wb_d   = 1'b1;
        cause_wb_d = is_load ? 4'd5 : 4'd7;
      end
    end
  end

  // State, wait counter and writeback register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      valid_wb_q <= 1'b0;
      pc_wb_q    <= '0;
      alu_wb_q   <= '0;
      instr_wb_q <= '0;
      load_wb_q  <= '0;
      exc_wb_q   <= 1'b0;
      cause_wb_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      valid_wb_q <= valid_wb_d;
      pc_wb_q    <= pc_wb_d;
      alu_wb_q   <= alu_wb_d;
      instr_wb_q <= instr_wb_d;
      load_wb_q  <= load_wb_d;
      exc_wb_q   <= exc_wb_d;
      cause_wb_q <= cause_wb_d;
    end
  end

  assign valid_wb = valid_wb_q;
  assign pc_wb    = pc_wb_q;
  assign alu_wb   = alu_wb_q;
  assign instr_wb = instr_wb_q;
  assign load_wb  = load_wb_q;
  assign exc_wb   = exc_wb_q;
  assign cause_wb = cause_wb_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_mem_access;
  localparam int XLEN    = 32;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        valid_mem = 1'b0, dmem_ack = 1'b0;
  logic [31:0] pc_mem = '0, alu_mem = '0, rs2_mem = '0, instr_mem = '0, dmem_rdata = '0;
  logic        dmem_req, dmem_we, stall_mem, valid_wb, exc_wb;
  logic [31:0] dmem_addr, dmem_wdata, pc_wb, alu_wb, load_wb, instr_wb;
  logic [3:0]  dmem_be, cause_wb;

  always #5 clk = ~clk;

  mem_access #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .valid_mem(valid_mem),
    .pc_mem(pc_mem), .alu_mem(alu_mem), .rs2_mem(rs2_mem), .instr_mem(instr_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall_mem(stall_mem), .pc_wb(pc_wb), .alu_wb(alu_wb), .load_wb(load_wb),
    .instr_wb(instr_wb), .valid_wb(valid_wb), .exc_wb(exc_wb), .cause_wb(cause_wb)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        req, we, stall, tmo, exc;
    logic [3:0]  be, cause;
    logic [31:0] addr, wdata, ld;
  } exp_t;

  // What the stage must present this cycle, given the current inputs and how
  // many cycles the current instruction has already been held.
  function automatic exp_t model(input int age);
    exp_t e;
    bit ld, st, al;
    int f3, bytes, a;
    logic [31:0] v, mask;
    e     = '0;
    ld    = (instr_mem[6:0] == 7'h03);
    st    = (instr_mem[6:0] == 7'h23);
    f3    = int'(instr_mem[14:12]);
    bytes = 1 << (f3 & 3);
    a     = int'(alu_mem[1:0]);
    al    = (a % bytes) == 0;
    e.req   = rst_n && valid_mem && (ld || st) && al;
    e.tmo   = e.req && (age == TIMEOUT - 1);
    e.stall = e.req && !dmem_ack && !e.tmo;
    if (e.req) begin
      e.we    = st;
      e.addr  = alu_mem & ~32'd3;
      e.be    = 4'(((1 << bytes) - 1) << a);
      e.wdata = (bytes == 1) ? rs2_mem[7:0] * 32'h01010101 :
                (bytes == 2) ? rs2_mem[15:0] * 32'h00010001 : rs2_mem;
    end
    if (valid_mem && ld && e.req && dmem_ack) begin
      v    = dmem_rdata >> (8 * a);
      mask = (bytes == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * bytes)) - 32'd1;
      v    = v & mask;
      if ((f3 & 4) == 0 && v[8*bytes-1]) v = v | ~mask;
      e.ld = v;
    end
    if (valid_mem && (ld || st) && !al) begin
      e.exc = 1'b1; e.cause = ld ? 4'd4 : 4'd6;
    end else if (e.tmo && !dmem_ack) begin
      e.exc = 1'b1; e.cause = ld ? 4'd5 : 4'd7;
    end
    return e;
  endfunction

  // Per-cycle comparison against the model, sampled mid-cycle
  exp_t        e;
  int          age = 0;
  logic        xv = 0, xexc = 0;
  logic [3:0]  xcause = 0;
  logic [31:0] xpc = 0, xalu = 0, xinstr = 0, xld = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst dmem_req", {31'd0, dmem_req}, 0);
      chk("rst dmem_we", {31'd0, dmem_we}, 0);
      chk("rst dmem_addr", dmem_addr, 0);
      chk("rst dmem_be", {28'd0, dmem_be}, 0);
      chk("rst dmem_wdata", dmem_wdata, 0);
      chk("rst stall", {31'd0, stall_mem}, 0);
      chk("rst valid_wb", {31'd0, valid_wb}, 0);
      chk("rst pc_wb", pc_wb, 0);
      chk("rst alu_wb", alu_wb, 0);
      chk("rst load_wb", load_wb, 0);
      chk("rst instr_wb", instr_wb, 0);
      chk("rst exc_wb", {31'd0, exc_wb}, 0);
      chk("rst cause_wb", {28'd0, cause_wb}, 0);
      xv = 0; xpc = 0; xalu = 0; xinstr = 0; xld = 0; xexc = 0; xcause = 0; age = 0;
    end else begin
      chk("valid_wb", {31'd0, valid_wb}, {31'd0, xv});
      chk("pc_wb", pc_wb, xpc);
      chk("alu_wb", alu_wb, xalu);
      chk("instr_wb", instr_wb, xinstr);
      chk("load_wb", load_wb, xld);
      chk("exc_wb", {31'd0, exc_wb}, {31'd0, xexc});
      chk("cause_wb", {28'd0, cause_wb}, {28'd0, xcause});
      e = model(age);
      chk("dmem_req", {31'd0, dmem_req}, {31'd0, e.req});
      chk("dmem_we", {31'd0, dmem_we}, {31'd0, e.we});
      chk("dmem_addr", dmem_addr, e.addr);
      chk("dmem_be", {28'd0, dmem_be}, {28'd0, e.be});
      chk("dmem_wdata", dmem_wdata, e.wdata);
      chk("stall_mem", {31'd0, stall_mem}, {31'd0, e.stall});
      if (e.stall) begin
        xv = 0; age++;
      end else begin
        xv = valid_mem; xpc = pc_mem; xalu = alu_mem; xinstr = instr_mem;
        xld = e.ld; xexc = e.exc; xcause = e.cause; age = 0;
      end
    end
  end

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
    logic [31:0] r;
    r = $urandom & 32'hFFFF_8F80;
    return r | {17'd0, f3, 5'd0, 7'd0} | {25'd0, op};
  endfunction

  // Present one instruction (entered at posedge+1) and hold it until the edge
  // that retires it; ack fires in cycle d of the instruction.
  task automatic run(input logic v, input logic [31:0] instr, input logic [31:0] alu,
                     input logic [31:0] rs2, input logic [31:0] rdata, input int d,
                     output int stalls, output logic s_req, output logic s_we,
                     output logic [3:0] s_be, output logic [31:0] s_wdata);
    int f3, r;
    bit mem, al;
    valid_mem = v; instr_mem = instr; alu_mem = alu; rs2_mem = rs2; pc_mem = $urandom;
    f3  = int'(instr[14:12]);
    al  = (int'(alu[1:0]) % (1 << (f3 & 3))) == 0;
    mem = v && (instr[6:0] == 7'h03 || instr[6:0] == 7'h23) && al;
    r   = mem ? ((d < TIMEOUT - 1) ? d : TIMEOUT - 1) : 0;
    stalls = 0; s_req = 0; s_we = 0; s_be = 0; s_wdata = 0;
    for (int c = 0; c <= r; c++) begin
      dmem_ack   = (c == d);
      dmem_rdata = (c == d) ? rdata : $urandom;
      #3;
      if (c == 0) begin
        s_req = dmem_req; s_we = dmem_we; s_be = dmem_be; s_wdata = dmem_wdata;
      end
      stalls += int'(stall_mem);
      @(posedge clk); #1;
    end
    dmem_ack = 1'b0;
  endtask

  int          st;
  logic        rq, we;
  logic [3:0]  be;
  logic [31:0] wd;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset valid_wb", {31'd0, valid_wb}, 0);
    chk("reset dmem_req", {31'd0, dmem_req}, 0);
    rst_n = 1'b1;

    // SW, zero-wait ack
    run(1, mk(7'h23, 3'd2), 32'h100, 32'hDEADBEEF, 0, 0, st, rq, we, be, wd);
    chk("sw be", {28'd0, be}, 32'hF);
    chk("sw wdata", wd, 32'hDEADBEEF);
    chk("sw we", {31'd0, we}, 1);
    chk("sw stalls", st, 0);
    chk("sw valid_wb", {31'd0, valid_wb}, 1);
    chk("sw exc_wb", {31'd0, exc_wb}, 0);

    // LB / LBU at 0x103 after 3 wait cycles
    run(1, mk(7'h03, 3'd0), 32'h103, 0, 32'h8000_0000, 3, st, rq, we, be, wd);
    chk("lb stalls", st, 3);
    chk("lb load_wb", load_wb, 32'hFFFF_FF80);
    run(1, mk(7'h03, 3'd4), 32'h103, 0, 32'h8000_0000, 3, st, rq, we, be, wd);
    chk("lbu load_wb", load_wb, 32'h0000_0080);

    // SH / LHU at 0x102
    run(1, mk(7'h23, 3'd1), 32'h102, 32'h1234ABCD, 0, 0, st, rq, we, be, wd);
    chk("sh be", {28'd0, be}, 32'hC);
    chk("sh wdata", wd, 32'hABCDABCD);
    run(1, mk(7'h03, 3'd5), 32'h102, 0, 32'hBEEF_0000, 1, st, rq, we, be, wd);
    chk("lhu load_wb", load_wb, 32'h0000_BEEF);

    // Misaligned accesses
    run(1, mk(7'h03, 3'd2), 32'h101, 0, 0, 0, st, rq, we, be, wd);
    chk("lw mis req", {31'd0, rq}, 0);
    chk("lw mis stalls", st, 0);
    chk("lw mis exc", {31'd0, exc_wb}, 1);
    chk("lw mis cause", {28'd0, cause_wb}, 4);
    run(1, mk(7'h23, 3'd1), 32'h201, 0, 0, 0, st, rq, we, be, wd);
    chk("sh mis cause", {28'd0, cause_wb}, 6);

    // Timeout, then ack on the final cycle
    run(1, mk(7'h03, 3'd2), 32'h300, 0, 0, 1000, st, rq, we, be, wd);
    chk("tmo stalls", st, 15);
    chk("tmo exc", {31'd0, exc_wb}, 1);
    chk("tmo cause", {28'd0, cause_wb}, 5);
    chk("tmo load_wb", load_wb, 0);
    run(1, mk(7'h03, 3'd2), 32'h300, 0, 32'h12345678, 15, st, rq, we, be, wd);
    chk("late ack stalls", st, 15);
    chk("late ack exc", {31'd0, exc_wb}, 0);
    chk("late ack load", load_wb, 32'h12345678);

    // Reset in the middle of a wait, then a stale ack
    valid_mem = 1; instr_mem = mk(7'h03, 3'd2); alu_mem = 32'h400; dmem_ack = 0;
    repeat (3) begin @(posedge clk); #1; end
    #2; rst_n = 1'b0; #1;
    chk("async rst req", {31'd0, dmem_req}, 0);
    chk("async rst stall", {31'd0, stall_mem}, 0);
    chk("async rst be", {28'd0, dmem_be}, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1; instr_mem = mk(7'h13, 3'd0); valid_mem = 1; dmem_ack = 1;
    #3;
    chk("stale ack req", {31'd0, dmem_req}, 0);
    @(posedge clk); #1;
    dmem_ack = 0;
    chk("addi valid_wb", {31'd0, valid_wb}, 1);
    chk("addi exc_wb", {31'd0, exc_wb}, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int k, dsel, d;
      logic [2:0] f3;
      logic [6:0] op;
      logic [2:0] ldf [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      k = int'($urandom_range(0, 3));
      if (k == 0) begin op = 7'h03; f3 = ldf[$urandom_range(0, 4)]; end
      else if (k == 1) begin op = 7'h23; f3 = 3'($urandom_range(0, 2)); end
      else begin op = (k == 2) ? 7'h33 : 7'h13; f3 = 3'($urandom); end
      dsel = int'($urandom_range(0, 7));
      d = (dsel < 5) ? dsel : (dsel == 5) ? TIMEOUT - 1 :
          (dsel == 6) ? TIMEOUT + 3 : int'($urandom_range(0, TIMEOUT - 1));
      run(($urandom_range(0, 7) != 0), mk(op, f3), $urandom, $urandom, $urandom, d,
          st, rq, we, be, wd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
